// File: rtl/pause_arbiter.sv
// pause_arbiter: single owner of the game core's pause line on clk_sys.
// It merges three pause sources:
//   - the user pause-button toggle;
//   - OSD-open pause;
//   - hiscore RAM-access requests, handled with a request/grant handshake.
// A hiscore grant is issued only after the CPU has been held paused for SETTLE_CYCLES.
// It also raises a screen-dim flag after a long user pause.
// Optional feature macro: PAUSE_DIM_EN. When it is undefined, the dim counter
// is not built and dim_video is held at 0.
module pause_arbiter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DIM_TIMEOUT   = 120000000,
  parameter int TIMER_W       = 32
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pause_btn,
  input  logic osd_open,
  input  logic osd_pause_en,
  input  logic hs_req,
  output logic hs_grant,
  output logic cpu_pause,
  output logic user_paused,
  output logic dim_video
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    GRANTED   = 2'd2,
    RELEASE   = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic       grant_q;
  logic       btn_q;
  logic       user_q;

  // Button edge detector and user toggle; btn_q resets high so a held button cannot toggle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_q  <= 1'b1;
      user_q <= 1'b0;
    end else begin
      btn_q <= pause_btn;
      if (pause_btn && !btn_q) begin
        user_q <= ~user_q;
      end
    end
  end

  // Hiscore handshake next-state: hold the CPU, wait out the settle time, grant, then release
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      RUN: begin
        if (hs_req) begin
          state_d  = HALT_WAIT;
          settle_d = 8'd0;
        end
      end
      HALT_WAIT: begin
        settle_d = settle_q + 8'd1;
        if (!hs_req) begin
          state_d = RUN;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!hs_req) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Hiscore state, settle counter and registered grant
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      settle_q <= 8'd0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      grant_q  <= (state_d == GRANTED);
    end
  end

  assign hs_grant    = grant_q;
  assign user_paused = user_q;
  assign cpu_pause   = user_q | (osd_open & osd_pause_en) | (state_q != RUN);

`ifdef PAUSE_DIM_EN
  localparam logic [TIMER_W-1:0] DIM_LIMIT = TIMER_W'(DIM_TIMEOUT);

  logic [TIMER_W-1:0] dim_cnt_q, dim_cnt_d;
  logic               dim_q, dim_d;

  // Dim counter counts user-pause time, saturating at the timeout; it clears as soon as the user unpauses
  always_comb begin
    dim_cnt_d = dim_cnt_q;
    dim_d     = user_q && (dim_cnt_q >= DIM_LIMIT);
    if (!user_q) begin
      dim_cnt_d = '0;
    end else if (dim_cnt_q < DIM_LIMIT) begin
      dim_cnt_d = dim_cnt_q + 1'b1;
    end
  end

  // Dim counter and dim flag registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dim_cnt_q <= '0;
      dim_q     <= 1'b0;
    end else begin
      dim_cnt_q <= dim_cnt_d;
      dim_q     <= dim_d;
    end
  end

  assign dim_video = dim_q;
`else
  // This build has no dim logic. The expression below is constant 0; it only references the timer parameters.
  assign dim_video = (TIMER_W < 1) && (DIM_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_pause_arbiter.sv
// tb_pause_arbiter: directed and randomized bench for pause_arbiter.
// A behavioural model tracks pause sources as durations and events.
// A per-cycle compare process checks the DUT against that model.
// Directed literal checks pin the model.
module tb_pause_arbiter;

  localparam int SETTLE = 4;
  localparam int DIM_T  = 20;
`ifdef PAUSE_DIM_EN
  localparam bit DIM_ON = 1'b1;
`else
  localparam bit DIM_ON = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic pause_btn = 1'b1;
  logic osd_open = 1'b0;
  logic osd_pause_en = 1'b0;
  logic hs_req = 1'b0;
  logic hs_grant, cpu_pause, user_paused, dim_video;

  int checks = 0;
  int errors = 0;

  pause_arbiter #(
    .SETTLE_CYCLES(SETTLE),
    .DIM_TIMEOUT  (DIM_T),
    .TIMER_W      (32)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pause_btn   (pause_btn),
    .osd_open    (osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_req      (hs_req),
    .hs_grant    (hs_grant),
    .cpu_pause   (cpu_pause),
    .user_paused (user_paused),
    .dim_video   (dim_video)
  );

  always #5 clk_sys = ~clk_sys;

  // Model state: user toggle, length of the current user pause, hiscore phase flags
  bit btnPrev, userExp, dimExp;
  bit hsWaiting, hsGranted, hsCooldown;
  int heldEdges, pausedLen;

  // Behavioural model updated on each clock edge from the bench's own inputs
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btnPrev    <= 1'b1;
      userExp    <= 1'b0;
      dimExp     <= 1'b0;
      hsWaiting  <= 1'b0;
      hsGranted  <= 1'b0;
      hsCooldown <= 1'b0;
      heldEdges  <= 0;
      pausedLen  <= 0;
    end else begin
      btnPrev <= pause_btn;
      if (pause_btn && !btnPrev) userExp <= !userExp;
      pausedLen <= userExp ? pausedLen + 1 : 0;
      dimExp    <= DIM_ON && userExp && (pausedLen >= DIM_T);
      if (hsCooldown) begin
        hsCooldown <= 1'b0;
      end else if (hsGranted) begin
        if (!hs_req) begin
          hsGranted  <= 1'b0;
          hsCooldown <= 1'b1;
        end
      end else if (hsWaiting) begin
        if (!hs_req) begin
          hsWaiting <= 1'b0;
        end else if (heldEdges + 1 == SETTLE) begin
          hsWaiting <= 1'b0;
          hsGranted <= 1'b1;
        end else begin
          heldEdges <= heldEdges + 1;
        end
      end else if (hs_req) begin
        hsWaiting <= 1'b1;
        heldEdges <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk_sys) begin
    if (!reset) begin
      checkOutput("hs_grant", hs_grant, hsGranted);
      checkOutput("user_paused", user_paused, userExp);
      checkOutput("dim_video", dim_video, dimExp);
      checkOutput("cpu_pause", cpu_pause,
                  userExp | (osd_open & osd_pause_en) | hsWaiting | hsGranted | hsCooldown);
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus();
    step();
    if (reset) begin
      reset = 1'b0;
    end else if ($urandom_range(399) == 0) begin
      reset = 1'b1;
    end
    if (pause_btn) pause_btn = ($urandom_range(1) == 0);
    else           pause_btn = ($urandom_range(39) == 0);
    if ($urandom_range(5) == 0)  hs_req = ~hs_req;
    if ($urandom_range(15) == 0) osd_open = ~osd_open;
    if ($urandom_range(63) == 0) osd_pause_en = ~osd_pause_en;
  endtask

  initial begin
    // Reset with the button held, outputs checked without a clock edge
    #2;
    checkOutput("rst_user", user_paused, 1'b0);
    checkOutput("rst_grant", hs_grant, 1'b0);
    checkOutput("rst_cpu", cpu_pause, 1'b0);
    #10 reset = 1'b0;
    step(); step(); step();
    checkOutput("held_btn_no_toggle", user_paused, 1'b0);

    // Button toggle on, then off
    pause_btn = 1'b0; step();
    pause_btn = 1'b1; step();
    checkOutput("toggle_on_user", user_paused, 1'b1);
    checkOutput("toggle_on_cpu", cpu_pause, 1'b1);
    pause_btn = 1'b0; step();
    pause_btn = 1'b1; step();
    checkOutput("toggle_off_user", user_paused, 1'b0);
    checkOutput("toggle_off_cpu", cpu_pause, 1'b0);
    pause_btn = 1'b0; step();

    // Full hiscore handshake
    hs_req = 1'b1; step();
    checkOutput("hs_halt_cpu", cpu_pause, 1'b1);
    checkOutput("hs_halt_grant", hs_grant, 1'b0);
    step(); step(); step();
    checkOutput("hs_settle3_grant", hs_grant, 1'b0);
    step();
    checkOutput("hs_settle4_grant", hs_grant, 1'b1);
    step(); step();
    hs_req = 1'b0; step();
    checkOutput("hs_release_grant", hs_grant, 1'b0);
    checkOutput("hs_release_cpu", cpu_pause, 1'b1);
    step();
    checkOutput("hs_run_cpu", cpu_pause, 1'b0);

    // Aborted request
    hs_req = 1'b1; step(); step();
    hs_req = 1'b0; step();
    checkOutput("abort_cpu", cpu_pause, 1'b0);
    checkOutput("abort_grant", hs_grant, 1'b0);

    // OSD pause
    osd_pause_en = 1'b1; osd_open = 1'b1; #1;
    checkOutput("osd_pause_cpu", cpu_pause, 1'b1);
    repeat (50) step();
    osd_open = 1'b0; #1;
    checkOutput("osd_closed_cpu", cpu_pause, 1'b0);
    osd_pause_en = 1'b0; osd_open = 1'b1; #1;
    checkOutput("osd_noen_cpu", cpu_pause, 1'b0);
    step(); osd_open = 1'b0;

    // Long user pause: dim timing
    pause_btn = 1'b1; step();
    pause_btn = 1'b0;
    repeat (20) step();
    checkOutput("dim_edge20", dim_video, 1'b0);
    step();
    checkOutput("dim_edge21", dim_video, DIM_ON);
    repeat (9) step();
    checkOutput("dim_held", dim_video, DIM_ON);
    pause_btn = 1'b1; step();
    checkOutput("unpause_user", user_paused, 1'b0);
    checkOutput("unpause_dim_same", dim_video, DIM_ON);
    pause_btn = 1'b0; step();
    checkOutput("unpause_dim_next", dim_video, 1'b0);

    // Asynchronous reset while granted and user-paused, then regrant
    pause_btn = 1'b1; step();
    pause_btn = 1'b0; hs_req = 1'b1;
    repeat (5) step();
    checkOutput("pre_rst_grant", hs_grant, 1'b1);
    #2 reset = 1'b1; #1;
    checkOutput("async_grant", hs_grant, 1'b0);
    checkOutput("async_user", user_paused, 1'b0);
    checkOutput("async_dim", dim_video, 1'b0);
    checkOutput("async_cpu", cpu_pause, 1'b0);
    step();
    #2 reset = 1'b0;
    step();
    checkOutput("regrant_halt_cpu", cpu_pause, 1'b1);
    step(); step(); step();
    checkOutput("regrant_wait", hs_grant, 1'b0);
    step();
    checkOutput("regrant_grant", hs_grant, 1'b1);
    hs_req = 1'b0; step(); step();
    checkOutput("regrant_done_cpu", cpu_pause, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) applyStimulus();
    reset = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
